// File: rtl/lime_pkg.sv
// Shared constants for the Lime processor input path: datapath width and input FIFO depth.
// Imported by lime_in_port, lime_fifo_mem, the core and the benches.
package lime_pkg;

   localparam int LIME_DATA_W   = 16;
   localparam int LIME_IN_DEPTH = 4;

   // Pointer width for a power-of-two FIFO of the given depth.
   function automatic int lime_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/lime_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module lime_fifo_mem
   import lime_pkg::*;
#(
   parameter int DEPTH  = LIME_IN_DEPTH,
   parameter int DATA_W = LIME_DATA_W,
   parameter int PTR_W  = lime_ptr_w(DEPTH)
) (
   input  logic              CLK,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/lime_in_port.sv
// Host-to-core input FIFO for the Lime processor (valid/ready push, one-cycle cpu_rd pop).
// Optional feature: define LIME_IN_HOLD_LAST_EN to hold the last popped word on main_input when empty.
module lime_in_port
   import lime_pkg::*;
#(
   parameter int DEPTH  = LIME_IN_DEPTH,
   parameter int DATA_W = LIME_DATA_W
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [DATA_W-1:0]        host_data,
   input  logic                     host_valid,
   output logic                     host_ready,
   input  logic                     cpu_rd,
   output logic [DATA_W-1:0]        main_input,
   output logic                     in_empty,
   output logic                     in_full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     underflow,
   input  logic                     clr_err
);

   localparam int PTR_W = lime_ptr_w(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              underflow_q, underflow_d;
   logic [DATA_W-1:0] head_data;
   logic              push, pop;

   // Handshake: a word transfers on any rising edge where host_valid && host_ready;
   // host_ready comes from registered count only, so it never depends on host_valid.
   assign in_empty   = (count_q == '0);
   assign in_full    = (count_q == CNT_W'(DEPTH));
   assign host_ready = !in_full;
   assign count      = count_q;
   assign underflow  = underflow_q;

   assign push = host_valid && host_ready;
   assign pop  = cpu_rd && !in_empty;

   lime_fifo_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .PTR_W  (PTR_W)
   ) u_mem (
      .CLK   (CLK),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (host_data),
      .raddr (rd_ptr_q),
      .rdata (head_data)
   );

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      underflow_d = underflow_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
      // A fresh empty read beats a clear arriving in the same cycle.
      if (clr_err) begin
         underflow_d = 1'b0;
      end
      if (cpu_rd && in_empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef LIME_IN_HOLD_LAST_EN
   logic [DATA_W-1:0] last_word_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_word_q <= '0;
      end else if (pop) begin
         last_word_q <= head_data;
      end
   end

   assign main_input = in_empty ? last_word_q : head_data;
`else
   assign main_input = in_empty ? '0 : head_data;
`endif

endmodule

// File: tb/tb_lime_in_port.sv
// Directed self-checking bench for lime_in_port (DEPTH=4, DATA_W=16).
// Honours LIME_IN_HOLD_LAST_EN for the empty-value expectations.
module tb_lime_in_port;

   localparam int W = 16;

   logic          CLK;
   logic          RST_N;
   logic [W-1:0]  host_data;
   logic          host_valid;
   logic          host_ready;
   logic          cpu_rd;
   logic [W-1:0]  main_input;
   logic          in_empty;
   logic          in_full;
   logic [2:0]    count;
   logic          underflow;
   logic          clr_err;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [W-1:0]  exp_q[$];

   lime_in_port #(.DEPTH(4), .DATA_W(W)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .host_data  (host_data),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .cpu_rd     (cpu_rd),
      .main_input (main_input),
      .in_empty   (in_empty),
      .in_full    (in_full),
      .count      (count),
      .underflow  (underflow),
      .clr_err    (clr_err)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock of stimulus: called at a negedge, returns at the next negedge with inputs idle.
   // exp_q is the bench's reference queue of words the core should see, in order.
   task automatic drive(input logic hv, input logic [W-1:0] hd, input logic rd, input logic clr);
      int sz;
      host_valid = hv;
      host_data  = hd;
      cpu_rd     = rd;
      clr_err    = clr;
      sz = exp_q.size();
      @(posedge CLK);
      if (rd && sz > 0) void'(exp_q.pop_front());
      if (hv && sz < 4) exp_q.push_back(hd);
      @(negedge CLK);
      host_valid = 1'b0;
      cpu_rd     = 1'b0;
      clr_err    = 1'b0;
   endtask

   task automatic push(input logic [W-1:0] d);
      drive(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic pop_check(input string tag, input logic [W-1:0] exp_head);
      check(tag, main_input, exp_head);
      if (exp_q.size() > 0) check({tag, "_sb"}, main_input, exp_q[0]);
      drive(1'b0, '0, 1'b1, 1'b0);
   endtask

   logic [W-1:0] empty_val;

   initial begin
      RST_N      = 1'b0;
      host_data  = '0;
      host_valid = 1'b0;
      cpu_rd     = 1'b0;
      clr_err    = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

      check("rst_count", count, 0);
      check("rst_empty", in_empty, 1);
      check("rst_full", in_full, 0);
      check("rst_ready", host_ready, 1);
      check("rst_underflow", underflow, 0);
      check("rst_main", main_input, 16'h0000);

      // single push into empty, then pop
      push(16'h0006);
      check("p1_main", main_input, 16'h0006);
      check("p1_count", count, 1);
      check("p1_empty", in_empty, 0);
      pop_check("p1_pop", 16'h0006);
`ifdef LIME_IN_HOLD_LAST_EN
      empty_val = 16'h0006;
`else
      empty_val = 16'h0000;
`endif
      check("p1_after_main", main_input, empty_val);
      check("p1_after_empty", in_empty, 1);

      // fill to full, overflow push dropped, pop at full
      push(16'h0011);
      push(16'h0022);
      push(16'h0033);
      push(16'h0044);
      check("full_flag", in_full, 1);
      check("full_ready", host_ready, 0);
      check("full_count", count, 4);
      push(16'h0055);
      check("ovf_count", count, 4);
      check("ovf_head", main_input, 16'h0011);
      check("fullpop_head", main_input, 16'h0011);
      drive(1'b1, 16'h0066, 1'b1, 1'b0);
      check("fullpop_count", count, 3);
      check("fullpop_ready", host_ready, 1);
      pop_check("drain_22", 16'h0022);
      pop_check("drain_33", 16'h0033);
      pop_check("drain_44", 16'h0044);
      check("drain_empty", in_empty, 1);
      check("drain_count", count, 0);
      check("drain_underflow", underflow, 0);

      // simultaneous push+pop mid-queue
      push(16'h00A1);
      push(16'h00A2);
      drive(1'b1, 16'h00A3, 1'b1, 1'b0);
      check("pp_count", count, 2);
      pop_check("pp_head_a2", 16'h00A2);
      pop_check("pp_tail_a3", 16'h00A3);
      check("pp_count0", count, 0);

      // underflow: set, clear, set-wins
      drive(1'b0, '0, 1'b1, 1'b0);
      check("uf_set", underflow, 1);
      check("uf_count", count, 0);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("uf_clr", underflow, 0);
      drive(1'b0, '0, 1'b1, 1'b1);
      check("uf_setwins", underflow, 1);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("uf_clr2", underflow, 0);
      // empty read with push: push succeeds, no fall-through
      drive(1'b1, 16'h0077, 1'b1, 1'b0);
      check("ep_count", count, 1);
      check("ep_main", main_input, 16'h0077);
      check("ep_underflow", underflow, 1);
      pop_check("ep_pop", 16'h0077);
      drive(1'b0, '0, 1'b0, 1'b1);

      // ten push/pop pairs, pointers wrap
      for (int i = 0; i < 10; i++) begin
         push(16'h0100 + 16'(i));
         pop_check($sformatf("wrap_%0d", i), 16'h0100 + 16'(i));
      end
`ifdef LIME_IN_HOLD_LAST_EN
      empty_val = 16'h0109;
`else
      empty_val = 16'h0000;
`endif
      check("wrap_final_main", main_input, empty_val);
      check("wrap_final_count", count, 0);
      check("wrap_underflow", underflow, 0);

      // asynchronous reset mid-run with three entries queued
      push(16'h0201);
      push(16'h0202);
      push(16'h0203);
      check("pre_rst_count", count, 3);
      #2;
      RST_N = 1'b0;
      #1;
      check("arst_count", count, 0);
      check("arst_empty", in_empty, 1);
      check("arst_ready", host_ready, 1);
      check("arst_main", main_input, 16'h0000);
      exp_q.delete();
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      check("post_rst_count", count, 0);
      push(16'h0301);
      check("post_rst_main", main_input, 16'h0301);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
